gpio_bus_arbiter: RTL and testbench

//  Two-master arbiter in front of the GPIO peripheral register port.

---
 rtl/gpio_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_bus_arbiter
//
// Purpose:
//   Two-master arbiter in front of the GPIO peripheral register port.
//   Master 0 is the core data port and master 1 is the debug/DMA port.
//   The arbiter grants at most one access per cycle using bounded-burst
//   round-robin. It drives the shared peripheral port and returns a
//   registered response to the granted master one cycle later.
//
// Parameters:
//   ADDR_W     peripheral word-address width
//   DATA_W     data width; the byte-enable width is DATA_W/8
//   MAX_BURST  maximum consecutive grants to one master while the other
//              master waits (1..15)
//
// Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   mX_req_i/we_i/be_i/addr_i/wdata_i
//                                master X request and access attributes
//   mX_gnt_o                     master X granted this cycle (combinational)
//   mX_rvalid_o, mX_rdata_o      master X response, one cycle after grant
//   write_o, data_be_o, addr_o, wdata_o
//                                shared peripheral access port
//   rdata_i                      peripheral read data, combinational from
//                                addr_o
// ---------------------------------------------------------------------------
module gpio_bus_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [DATA_W/8-1:0]   m0_be_i,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    input  logic [DATA_W-1:0]     m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_W-1:0]     m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [DATA_W/8-1:0]   m1_be_i,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic [DATA_W-1:0]     m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_W-1:0]     m1_rdata_o,

    output logic                  write_o,
    output logic [DATA_W/8-1:0]   data_be_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [DATA_W-1:0]     wdata_o,
    input  logic [DATA_W-1:0]     rdata_i
);

    localparam int          BE_W        = DATA_W / 8;
    localparam logic [3:0]  MAX_BURST_C = 4'(MAX_BURST);
    localparam logic [3:0]  BURST_SAT   = 4'd15;

    logic              last_q;
    logic [3:0]        burst_q;
    logic              rsp_sel_q;
    logic              rsp_v_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic gnt0;
    logic gnt1;
    logic any_gnt;
    logic keep_owner;

    // Grant selection. While reset is asserted nothing is granted, so the
    // peripheral port stays quiet even though the masters may be requesting.
    // On a tie the last owner keeps the port only while it is inside a running
    // burst below the limit. With no running burst (after reset or an idle
    // cycle) the tie goes to the other master, which is what lets M0 win the
    // first tie out of reset with last_q=1.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        keep_owner = (burst_q != 4'd0) && (burst_q < MAX_BURST_C);
        if (rst_ni) begin
            if (m0_req_i && !m1_req_i) begin
                gnt0 = 1'b1;
            end else if (m1_req_i && !m0_req_i) begin
                gnt1 = 1'b1;
            end else if (m0_req_i && m1_req_i) begin
                if (keep_owner) begin
                    gnt1 = last_q;
                end else begin
                    gnt1 = ~last_q;
                end
                gnt0 = ~gnt1;
            end
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // Peripheral port mux; every field is forced to zero when idle.
    always_comb begin
        write_o   = 1'b0;
        data_be_o = '0;
        addr_o    = '0;
        wdata_o   = '0;
        if (gnt0) begin
            write_o   = m0_we_i;
            data_be_o = m0_be_i;
            addr_o    = m0_addr_i;
            wdata_o   = m0_wdata_i;
        end else if (gnt1) begin
            write_o   = m1_we_i;
            data_be_o = m1_be_i;
            addr_o    = m1_addr_i;
            wdata_o   = m1_wdata_i;
        end
    end

    // Arbitration state and registered response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= 1'b1;
            burst_q    <= 4'd0;
            rsp_sel_q  <= 1'b0;
            rsp_v_q    <= 1'b0;
            rsp_data_q <= '0;
        end else if (any_gnt) begin
            rsp_v_q    <= 1'b1;
            rsp_sel_q  <= gnt1;
            rsp_data_q <= write_o ? '0 : rdata_i;
            if (gnt1 == last_q) begin
                burst_q <= (burst_q == BURST_SAT) ? BURST_SAT : burst_q + 4'd1;
            end else begin
                burst_q <= 4'd1;
                last_q  <= gnt1;
            end
        end else begin
            rsp_v_q <= 1'b0;
            burst_q <= 4'd0;
        end
    end

    assign m0_rvalid_o = rsp_v_q & ~rsp_sel_q;
    assign m1_rvalid_o = rsp_v_q &  rsp_sel_q;
    assign m0_rdata_o  = m0_rvalid_o ? rsp_data_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rsp_data_q : '0;

    logic unused_be_w;
    assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpio_bus_arbiter
//
// Directed testbench for gpio_bus_arbiter with a small byte-enabled register
// file standing in for the GPIO peripheral.
// ---------------------------------------------------------------------------
module tb_gpio_bus_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [BE_W-1:0]   m0_be, m1_be;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              write;
    logic [BE_W-1:0]   data_be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mem [0:63];

    gpio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .write_o(write), .data_be_o(data_be), .addr_o(addr),
        .wdata_o(wdata), .rdata_i(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model: byte-enabled register file, combinational read.
    initial for (int i = 0; i < 64; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (write) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data_be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
    assign rdata = mem[addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    // Expected contention pattern as {m1_gnt, m0_gnt}.
    logic [1:0] pat [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                             2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset with both masters requesting
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = 6'h05; m0_wdata = 32'h11;
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_addr = 6'h06; m1_wdata = 32'h22;
        #3;
        check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_addr", {26'd0, addr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("first_tie", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        check("t1_write", {31'd0, write}, 32'd1);
        check("t1_addr", {26'd0, addr}, 32'h05);
        tick();
        check("t1_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
        check("t1_wr_rdata", m0_rdata, 32'd0);
        // reset asserted while the next access is in flight
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("midrst_write", {31'd0, write}, 32'd0);
        check("midrst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // T2: single master write then read of 0x04
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'b0011; m0_addr = 6'h04; m0_wdata = 32'h0000A5A5;
        #1;
        check("t2_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        check("t2_write", {31'd0, write}, 32'd1);
        check("t2_be", {28'd0, data_be}, 32'h3);
        check("t2_addr", {26'd0, addr}, 32'h04);
        check("t2_wdata", wdata, 32'h0000A5A5);
        tick();
        m0_we = 1'b0; m0_be = 4'hF;
        #1;
        check("t2_rd_write", {31'd0, write}, 32'd0);
        check("t2_rd_addr", {26'd0, addr}, 32'h04);
        check("t2_rvalid1", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
        check("t2_wr_rsp", m0_rdata, 32'd0);
        tick();
        idle();
        check("t2_rvalid2", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
        check("t2_rdata", m0_rdata, 32'h0000A5A5);
        tick();
        check("t2_done", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // T3: continuous contention from reset, reads
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'h05;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'h02;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("t3_gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, {30'd0, pat[i]});
            if (i > 0)
                check($sformatf("t3_rv%0d", i), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, pat[i-1]});
            if (i == 1) check("t3_rdata_m0", m0_rdata, 32'h11);
            if (i == 5) check("t3_rdata_m1", m1_rdata, 32'h0);
            tick();
        end

        // T4: M1 alone for 10 cycles, then M0 joins
        m0_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("t4_m1_%0d", i), {30'd0, m1_gnt, m0_gnt}, 32'b10);
            tick();
        end
        m0_req = 1'b1;
        #1;
        check("t4_m0_join", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        tick();

        // T5: M0 writes 0x30, M1 reads it the next cycle
        idle();
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = 6'h30; m0_wdata = 32'h1;
        #1;
        check("t5_wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = 6'h30;
        #1;
        check("t5_rd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
        check("t5_rv_n1", {30'd0, m1_rvalid, m0_rvalid}, 32'b01);
        tick();
        m1_req = 1'b0;
        #1;
        check("t5_rv_n2", {30'd0, m1_rvalid, m0_rvalid}, 32'b10);
        check("t5_m1_rdata", m1_rdata, 32'h1);
        check("t5_m0_rdata", m0_rdata, 32'h0);

        // T6: idle port, then tie after M1 grant and an idle cycle
        tick();
        check("t6_write", {31'd0, write}, 32'd0);
        check("t6_addr", {26'd0, addr}, 32'd0);
        check("t6_be", {28'd0, data_be}, 32'd0);
        check("t6_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        m1_req = 1'b1;
        #1;
        check("t6_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
        tick();
        m1_req = 1'b0;
        tick();
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        check("t6_tie", {30'd0, m1_gnt, m0_gnt}, 32'b01);
        tick();
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
